// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester shared signed adder.
// Optional round-robin arbitration is enabled with `define ADDER_ARB_RR_EN.
package adder_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int OP_W  = 4;
    localparam int RES_W = 5;

    // Sign-extend both operands one bit and add; the carry out of RES_W is dropped.
    function automatic logic [RES_W-1:0] sext_add(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        return {a[OP_W-1], a} + {b[OP_W-1], b};
    endfunction

endpackage

// File: rtl/adder_arb_if.sv
// Request/response bundle between the requesters/consumer and adder_arb.
// Used identically whether or not ADDER_ARB_RR_EN is defined.
interface adder_arb_if #(parameter int CNT_W = 8);
    import adder_arb_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_a;
    logic [OP_W-1:0]  req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_a;
    logic [OP_W-1:0]  req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_sum;
    logic             rsp_ovf;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, cnt0, cnt1
    );

endinterface

// File: rtl/adder_arb_pick.sv
// Grant selection for the two requesters.
// ADDER_ARB_RR_EN defined: round-robin on contention; otherwise requester 0 wins.
module adder_arb_pick (
    input  logic valid0,
    input  logic valid1,
`ifdef ADDER_ARB_RR_EN
    input  logic ptr,
`endif
    input  logic slot_free,
    output logic grant0,
    output logic grant1
);

`ifdef ADDER_ARB_RR_EN
    // ptr holds the last granted requester; on contention the other one wins.
    assign grant0 = slot_free & valid0 & (~valid1 | ptr);
    assign grant1 = slot_free & valid1 & (~valid0 | ~ptr);
`else
    assign grant0 = slot_free & valid0;
    assign grant1 = slot_free & valid1 & ~valid0;
`endif

endmodule

// File: rtl/adder_arb.sv
// Two requesters share one signed 4-bit adder feeding a single registered response slot.
// ADDER_ARB_RR_EN selects round-robin arbitration (default: fixed priority to requester 0).
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_arb_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic             slot_free;
    logic             grant0, grant1;
    logic             accept, drain;
    logic [OP_W-1:0]  op_a, op_b;
    logic [RES_W-1:0] sum_nx;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_sum;
    logic [CNT_W-1:0] cnt0, cnt1;

    // Gating with rst_n keeps both readies low while reset is asserted.
    assign slot_free = rst_n & ((state == EMPTY) | bus.rsp_ready);
    assign drain     = (state == FULL) & bus.rsp_ready;
    assign accept    = grant0 | grant1;

`ifdef ADDER_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n)      last_grant <= 1'b1;
        else if (accept) last_grant <= grant1;
    end
`endif

    adder_arb_pick u_pick (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
`ifdef ADDER_ARB_RR_EN
        .ptr       (last_grant),
`endif
        .slot_free (slot_free),
        .grant0    (grant0),
        .grant1    (grant1)
    );

    assign op_a   = grant1 ? bus.req1_a : bus.req0_a;
    assign op_b   = grant1 ? bus.req1_b : bus.req0_b;
    assign sum_nx = sext_add(op_a, op_b);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (accept)          state_nx = FULL;
            FULL:  if (drain & ~accept) state_nx = EMPTY;
            default:                    state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id  <= 1'b0;
            rsp_sum <= '0;
        end else if (accept) begin
            rsp_id  <= grant1;
            rsp_sum <= sum_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (drain) begin
            if (!rsp_id && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
            if ( rsp_id && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state == FULL);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_sum    = rsp_sum;
    assign bus.rsp_ovf    = rsp_sum[RES_W-1] ^ rsp_sum[RES_W-2];
    assign bus.cnt0       = cnt0;
    assign bus.cnt1       = cnt1;

endmodule

// File: tb/tb_adder_arb.sv
// Directed bench for adder_arb: a CNT_W=8 and a CNT_W=2 instance share the same stimulus.
// Expected arbitration order follows ADDER_ARB_RR_EN.
module tb_adder_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    adder_arb_if #(.CNT_W(8)) bus ();
    adder_arb_if #(.CNT_W(2)) bus2 ();

    assign bus2.req0_valid = bus.req0_valid;
    assign bus2.req0_a     = bus.req0_a;
    assign bus2.req0_b     = bus.req0_b;
    assign bus2.req1_valid = bus.req1_valid;
    assign bus2.req1_a     = bus.req1_a;
    assign bus2.req1_b     = bus.req1_b;
    assign bus2.rsp_ready  = bus.rsp_ready;

    adder_arb #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    adder_arb #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one pair from requester k, then check the registered result a cycle later.
    task automatic xfer(input int k, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp_sum, input logic exp_ovf);
        if (k == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        chk("ready_k", (k == 0) ? int'(bus.req0_ready) : int'(bus.req1_ready), 1);
        chk("ready_other", (k == 0) ? int'(bus.req1_ready) : int'(bus.req0_ready), 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("rsp_valid", int'(bus.rsp_valid), 1);
        chk("rsp_id", int'(bus.rsp_id), k);
        chk("rsp_sum", int'(bus.rsp_sum), int'(exp_sum));
        chk("rsp_ovf", int'(bus.rsp_ovf), int'(exp_ovf));
    endtask

    initial begin
        int exp_sat[4];
        int exp_id[4];
        int exp_sum[4];
        exp_sat = '{2, 3, 3, 3};
`ifdef ADDER_ARB_RR_EN
        exp_id  = '{0, 1, 0, 1};
        exp_sum = '{2, 4, 2, 4};
`else
        exp_id  = '{0, 0, 0, 0};
        exp_sum = '{2, 2, 2, 2};
`endif

        rst_n          = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;

        // Reset state, readies held low during reset even with requests pending
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rst_ready0", int'(bus.req0_ready), 0);
        chk("rst_ready1", int'(bus.req1_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_rsp_sum", int'(bus.rsp_sum), 0);
        chk("rst_rsp_ovf", int'(bus.rsp_ovf), 0);
        chk("rst_cnt0", int'(bus.cnt0), 0);
        chk("rst_cnt1", int'(bus.cnt1), 0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n          = 1'b1;

        // Single transfer 3+4 from requester 0
        xfer(0, 4'd3, 4'd4, 5'b00111, 1'b0);
        @(negedge clk); #1;
        chk("a_rsp_valid_after_drain", int'(bus.rsp_valid), 0);
        chk("a_cnt0", int'(bus.cnt0), 1);
        chk("a_cnt0_w2", int'(bus2.cnt0), 1);

        // Overflow boundaries from requester 1, issued back to back
        xfer(1, 4'd7, 4'd7, 5'b01110, 1'b1);
        xfer(1, 4'h8, 4'h8, 5'b10000, 1'b1);
        xfer(1, 4'hF, 4'h1, 5'b00000, 1'b0);
        @(negedge clk); #1;
        chk("b_rsp_valid", int'(bus.rsp_valid), 0);
        chk("b_cnt1", int'(bus.cnt1), 3);
        chk("b_cnt0", int'(bus.cnt0), 1);

        // Counter saturation at CNT_W=2: cnt0 sequence continues 2,3,3,3
        for (int i = 0; i < 4; i++) begin
            xfer(0, 4'(i), 4'd1, 5'(i + 1), 1'b0);
            @(negedge clk); #1;
            chk("sat_cnt0_w2", int'(bus2.cnt0), exp_sat[i]);
            chk("sat_cnt0_w8", int'(bus.cnt0), i + 2);
        end

        // Backpressure: hold result 3 cycles, then drain and refill in one cycle
        xfer(0, 4'd2, 4'd3, 5'd5, 1'b0);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        #1;
        chk("bp_ready0", int'(bus.req0_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
            chk("bp_rsp_sum", int'(bus.rsp_sum), 5);
            chk("bp_rsp_id", int'(bus.rsp_id), 0);
            chk("bp_ready0", int'(bus.req0_ready), 0);
            chk("bp_ready1", int'(bus.req1_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("refill_ready0", int'(bus.req0_ready), 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("refill_rsp_valid", int'(bus.rsp_valid), 1);
        chk("refill_rsp_sum", int'(bus.rsp_sum), 2);
        chk("refill_cnt0", int'(bus.cnt0), 6);
        @(negedge clk); #1;
        chk("refill_empty", int'(bus.rsp_valid), 0);
        chk("refill_cnt0_b", int'(bus.cnt0), 7);

        // Reset while FULL and stalled; last grant before reset was requester 0
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        chk("pre_rst_full", int'(bus.rsp_valid), 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst2_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst2_cnt0", int'(bus.cnt0), 0);
        chk("rst2_cnt1", int'(bus.cnt1), 0);

        // Both requesters valid continuously after reset
        rst_n          = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2;
        #1;
        chk("cont_ready0", int'(bus.req0_ready), 1);
        chk("cont_ready1", int'(bus.req1_ready), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("cont_rsp_valid", int'(bus.rsp_valid), 1);
            chk("cont_rsp_id", int'(bus.rsp_id), exp_id[i]);
            chk("cont_rsp_sum", int'(bus.rsp_sum), exp_sum[i]);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("cont_empty", int'(bus.rsp_valid), 0);
`ifdef ADDER_ARB_RR_EN
        chk("cont_cnt0", int'(bus.cnt0), 2);
        chk("cont_cnt1", int'(bus.cnt1), 2);
`else
        chk("cont_cnt0", int'(bus.cnt0), 4);
        chk("cont_cnt1", int'(bus.cnt1), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
